// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - framed byte-stream image loader into instruction memory
// Optional feature macro: BOOT_CHECKSUM_EN (trailing XOR checksum byte and CSUM state).
module boot_loader #(
    parameter int         ADDR_W   = 8,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              boot_done,
    output logic              boot_error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
`ifdef BOOT_CHECKSUM_EN
        S_CSUM   = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

`ifdef BOOT_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CSUM;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    // A length equal to the full memory size is legal; only larger values are rejected.
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         len_lo;
    logic [15:0]        len;
    logic [1:0]         byte_cnt;
    logic [23:0]        shift;
    logic [ADDR_W-1:0]  wr_ptr;
    logic               last_word;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    assign last_word = (byte_cnt == 2'd3) && ((words_loaded + 16'd1) == len);

    always_comb begin
        state_nxt    = state;
        rx_ready     = 1'b0;
        boot_done    = 1'b0;
        boot_error   = 1'b0;
        core_reset_n = 1'b0;
        case (state)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid && rx_data == HDR_BYTE)
                    state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid)
                    state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if ({1'b0, rx_data, len_lo} > MAX_WORDS)
                        state_nxt = S_ERROR;
                    else if ({rx_data, len_lo} == 16'd0)
                        state_nxt = S_AFTER_DATA;
                    else
                        state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (rx_valid && last_word)
                    state_nxt = S_AFTER_DATA;
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                rx_ready = 1'b1;
                if (rx_valid)
                    state_nxt = (rx_data == csum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE: begin
                boot_done    = 1'b1;
                core_reset_n = 1'b1;
            end
            S_ERROR: begin
                boot_error = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state        <= S_IDLE;
            len_lo       <= 8'd0;
            len          <= 16'd0;
            byte_cnt     <= 2'd0;
            shift        <= 24'd0;
            wr_ptr       <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            words_loaded <= 16'd0;
`ifdef BOOT_CHECKSUM_EN
            csum         <= 8'd0;
`endif
        end else begin
            state   <= state_nxt;
            imem_we <= 1'b0;
            if (rx_valid && rx_ready) begin
                case (state)
                    S_IDLE: begin
                        byte_cnt <= 2'd0;
`ifdef BOOT_CHECKSUM_EN
                        if (rx_data == HDR_BYTE)
                            csum <= 8'd0;
`endif
                    end
                    S_LEN_LO: len_lo <= rx_data;
                    S_LEN_HI: len    <= {rx_data, len_lo};
                    S_DATA: begin
                        // Little-endian: earlier bytes shift toward bit 0.
                        byte_cnt <= byte_cnt + 2'd1;
                        shift    <= {rx_data, shift[23:8]};
`ifdef BOOT_CHECKSUM_EN
                        csum     <= csum ^ rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= wr_ptr;
                            imem_wdata   <= {rx_data, shift};
                            wr_ptr       <= wr_ptr + 1'b1;
                            words_loaded <= words_loaded + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
